// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor: DIFF = A - B - BORROW_IN over WIDTH bits, one
// nibble per clock (LSB first) through a single 4-bit P/G adder slice that
// computes A + ~B + ~borrow.
// Optional macro SUB_SIGNED_SAT_EN: when defined, DIFF saturates to the signed
// extreme on overflow (OVF/BORROW_OUT still report the raw result).
module nibble_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BORROW_IN,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] DIFF,
  output logic             BORROW_OUT,
  output logic             ZERO,
  output logic             OVF
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [NIB-1:0][3:0]    a_q, a_d, b_q, b_d, res_q, res_d;
  logic                   borrow_q, borrow_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]       diff_q, diff_d;
  logic                   bout_q, bout_d, zero_q, zero_d, ovf_q, ovf_d;

  // Shared nibble slice: propagate/generate over A + ~B, carry-in = ~borrow.
  logic [3:0] s_a, s_nb, s_p, s_g, s_sum;
  logic [4:0] s_c;
  logic [WIDTH-1:0] full_res, fin_diff;
  logic             raw_ovf;

  // Nibble k of the captured operands through the 4-bit carry chain.
  always_comb begin
    s_a    = a_q[cnt_q];
    s_nb   = ~b_q[cnt_q];
    s_p    = s_a ^ s_nb;
    s_g    = s_a & s_nb;
    s_c[0] = ~borrow_q;
    for (int i = 0; i < 4; i++) s_c[i+1] = s_g[i] | (s_p[i] & s_c[i]);
    s_sum  = s_p ^ s_c[3:0];
  end

  // State, operand and result registers; reset discards any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    full_res = '0;
    fin_diff = '0;
    raw_ovf  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = A;
          b_d      = B;
          borrow_d = BORROW_IN;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        res_d[cnt_q] = s_sum;
        borrow_d     = ~s_c[4];
        cnt_d        = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          full_res = res_d;
          raw_ovf  = (a_q[NIB-1][3] != b_q[NIB-1][3]) &&
                     (full_res[WIDTH-1] != a_q[NIB-1][3]);
`ifdef SUB_SIGNED_SAT_EN
          // Overflow pins the result to the signed extreme matching A's sign.
          fin_diff = raw_ovf ? {a_q[NIB-1][3], {(WIDTH-1){~a_q[NIB-1][3]}}}
                             : full_res;
`else
          fin_diff = full_res;
`endif
          diff_d  = fin_diff;
          bout_d  = ~s_c[4];
          zero_d  = (fin_diff == '0);
          ovf_d   = raw_ovf;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign DIFF       = diff_q;
  assign BORROW_OUT = bout_q;
  assign ZERO       = zero_q;
  assign OVF        = ovf_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed bench for nibble_serial_subtractor at WIDTH=16.
module tb_nibble_serial_subtractor;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, in_valid, out_ready, BORROW_IN;
  logic [W-1:0] A, B;
  logic         in_ready, out_valid, BORROW_OUT, ZERO, OVF;
  logic [W-1:0] DIFF;

  int cmp_cnt = 0;
  int err_cnt = 0;

  nibble_serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .BORROW_IN(BORROW_IN), .out_valid(out_valid),
    .out_ready(out_ready), .DIFF(DIFF), .BORROW_OUT(BORROW_OUT),
    .ZERO(ZERO), .OVF(OVF)
  );

  always #5 clk = ~clk;

  // Present one operand set for one accept edge; returns at the next negedge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    @(negedge clk);
    A = a; B = b; BORROW_IN = bin; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Negedges after the accept edge until out_valid, bounded at 20.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cmp_cnt++;
    if ({in_ready, out_valid, DIFF, BORROW_OUT, ZERO, OVF} !== {2'b10, 16'h0, 3'b000}) begin
      err_cnt++;
      $display("FAIL reset: got rdy=%b vld=%b diff=%h bo=%b z=%b ovf=%b, want rdy=1 vld=0 diff=0000 flags 0",
               in_ready, out_valid, DIFF, BORROW_OUT, ZERO, OVF);
    end
  endtask

  // One full operation with latency and result checks.
  task automatic check_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic bin, input logic [W-1:0] ed, input logic ebo,
                          input logic ez, input logic eo);
    int lat;
    start_op(a, b, bin);
    cmp_cnt++;
    if (in_ready !== 1'b0) begin
      err_cnt++;
      $display("FAIL %s in_ready_after_accept: got %b want 0", name, in_ready);
    end
    wait_done(lat);
    cmp_cnt++;
    if (lat !== 4) begin
      err_cnt++;
      $display("FAIL %s latency: got %0d want 4", name, lat);
    end
    cmp_cnt++;
    if ({DIFF, BORROW_OUT, ZERO, OVF} !== {ed, ebo, ez, eo}) begin
      err_cnt++;
      $display("FAIL %s result: got diff=%h bo=%b z=%b ovf=%b want diff=%h bo=%b z=%b ovf=%b",
               name, DIFF, BORROW_OUT, ZERO, OVF, ed, ebo, ez, eo);
    end
    finish_op();
    cmp_cnt++;
    if ({in_ready, out_valid} !== 2'b10) begin
      err_cnt++;
      $display("FAIL %s release: got rdy=%b vld=%b want rdy=1 vld=0", name, in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    check_op("basic", 16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    check_op("wrap", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
`ifdef SUB_SIGNED_SAT_EN
    check_op("ovf_neg", 16'h8000, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1);
    check_op("ovf_pos", 16'h7FFF, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b0, 1'b1);
`else
    check_op("ovf_neg", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1);
    check_op("ovf_pos", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1);
`endif
  endtask

  task automatic test_borrow_chain();
    check_op("zero_bin", 16'h0005, 16'h0004, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0);
    check_op("chain", 16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int lat;
    start_op(16'hABCD, 16'h1111, 1'b0);
    // In-valid pulse during RUN must be ignored.
    in_valid = 1'b1; A = 16'h0000; B = 16'hFFFF; BORROW_IN = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(lat);
    cmp_cnt++;
    if (lat !== 3) begin
      err_cnt++;
      $display("FAIL bp latency: got %0d want 3 negedges after pulse", lat);
    end
    for (int i = 0; i < 3; i++) begin
      in_valid = (i == 1);
      @(negedge clk);
      cmp_cnt++;
      if ({out_valid, in_ready, DIFF, BORROW_OUT, ZERO, OVF} !== {2'b10, 16'h9ABC, 3'b000}) begin
        err_cnt++;
        $display("FAIL bp hold%0d: got vld=%b rdy=%b diff=%h bo=%b z=%b ovf=%b want vld=1 rdy=0 diff=9abc flags 0",
                 i, out_valid, in_ready, DIFF, BORROW_OUT, ZERO, OVF);
      end
    end
    in_valid = 1'b0;
    finish_op();
    cmp_cnt++;
    if ({in_ready, out_valid} !== 2'b10) begin
      err_cnt++;
      $display("FAIL bp release: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
    end
    check_op("bp_next", 16'h0100, 16'h0001, 1'b1, 16'h00FE, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    bit seen = 0;
    start_op(16'h4444, 16'h1111, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cmp_cnt++;
    if ({in_ready, out_valid, DIFF, BORROW_OUT, ZERO, OVF} !== {2'b10, 16'h0, 3'b000}) begin
      err_cnt++;
      $display("FAIL mid_reset: got rdy=%b vld=%b diff=%h bo=%b z=%b ovf=%b want rdy=1 vld=0 diff=0000 flags 0",
               in_ready, out_valid, DIFF, BORROW_OUT, ZERO, OVF);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    cmp_cnt++;
    if (seen !== 1'b0) begin
      err_cnt++;
      $display("FAIL mid_reset_no_output: got out_valid seen=%b want 0", seen);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; BORROW_IN = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_overflow();
    test_borrow_chain();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/nibble_serial_subtractor.md
Name: nibble_serial_subtractor

Overview:
Multi-cycle subtractor computing DIFF = A - B - BORROW_IN over WIDTH-bit operands, one 4-bit nibble per clock, LSB nibble first.
- Each cycle reuses a single 4-bit propagate/generate adder slice on A + ~B with inverted borrow as carry; borrow = ~carry.
- Sits beside the combinational adder in the ALU datapath. Provides the subtract direction with a valid/ready handshake, so wide operands cost one nibble slice instead of a full-width chain.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand set presented
in_ready  output  1  block can accept operands
A  input  WIDTH  minuend
B  input  WIDTH  subtrahend
BORROW_IN  input  1  borrow into LSB
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
DIFF  output  WIDTH  A - B - BORROW_IN, mod 2^WIDTH
BORROW_OUT  output  1  borrow out of MSB; 1 iff unsigned A < B + BORROW_IN
ZERO  output  1  DIFF == 0
OVF  output  1  two's-complement signed overflow of the subtraction

Behaviour:
- Reset (rst high at a rising edge) forces state IDLE.
  - in_ready=1, out_valid=0; DIFF, BORROW_OUT, ZERO, OVF = 0.
  - Nibble counter = 0; operand registers cleared.
  - Reset has priority over every other event, including a mid-RUN or DONE operation, which is discarded with no output.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid && in_ready: capture A, B and BORROW_IN into internal registers, set borrow register = BORROW_IN, counter = 0, go to RUN.
  - Input changes after the capture edge have no effect.
- RUN:
  - in_ready=0, out_valid=0.
  - Each edge processes nibble k = counter:
    - d[3:0] = A[4k+3:4k] + ~B[4k+3:4k] + ~borrow, computed with the 4-bit P/G carry chain.
    - Store d into result nibble k.
    - borrow <= ~carry_out; counter increments.
  - On the edge processing k = WIDTH/4-1, latch the output registers and go to DONE:
    - DIFF = full result.
    - BORROW_OUT = final borrow.
    - ZERO = (result == 0).
    - OVF = (A[MSB] != B[MSB]) && (DIFF[MSB] != A[MSB]).
- DONE:
  - out_valid=1, in_ready=0.
  - DIFF and all flags hold stable while out_ready=0.
  - On out_ready=1: go to IDLE; out_valid falls after that edge; in_ready is 1 in the following cycle.
  - Outputs keep their last values in IDLE and RUN and change only on entry to DONE.
- Latency: out_valid rises exactly WIDTH/4 cycles after the accept edge (4 cycles at WIDTH=16).
  - Throughput: one operation per WIDTH/4+2 cycles when out_ready is held high.
- No accept while RUN/DONE: in_valid is ignored and the operands are not captured. The source must hold in_valid until in_ready.
- out_ready asserted outside DONE has no effect.
- Wrap-around: the result is modulo 2^WIDTH, e.g. 0 - 1 = all ones with BORROW_OUT=1.
- WIDTH=4: RUN lasts one cycle.

Optional Feature:
Macro SUB_SIGNED_SAT_EN.
- Defined: on OVF=1, DIFF is replaced at DONE entry by the signed saturation value.
  - A[MSB]=0 gives 0x7FF..F (max positive); A[MSB]=1 gives 0x800..0 (max negative).
  - OVF and BORROW_OUT still report the raw subtraction.
  - ZERO is computed on the saturated DIFF.
- Undefined: DIFF is always the wrapped modulo result; no saturation logic is present.

Test Plan:
- WIDTH=16. Reset, then A=0x1234, B=0x0034, BORROW_IN=0, in_valid for one cycle.
  -> in_ready drops; out_valid rises 4 cycles after accept with DIFF=0x1200, BORROW_OUT=0, ZERO=0, OVF=0.
- A=0x0000, B=0x0001, BORROW_IN=0 -> DIFF=0xFFFF, BORROW_OUT=1, ZERO=0, OVF=0 (wrap-around).
- A=0x8000, B=0x0001 -> OVF=1, BORROW_OUT=0.
  - DIFF=0x7FFF without SUB_SIGNED_SAT_EN.
  - DIFF=0x8000 with SUB_SIGNED_SAT_EN.
- A=0x0005, B=0x0004, BORROW_IN=1 -> DIFF=0x0000, ZERO=1, BORROW_OUT=0.
  - A chained nibble borrow case, A=0x1000, B=0x0001 -> DIFF=0x0FFF.
- Backpressure: out_ready held 0 for 3 cycles in DONE.
  - DIFF and flags stay stable; in_valid pulses during RUN/DONE are ignored.
  - out_ready=1 -> IDLE, in_ready=1 next cycle; the next operation completes correctly.
- Reset mid-operation: rst high on the 2nd RUN cycle -> next cycle in_ready=1, out_valid=0, DIFF=0, all flags 0; no result is ever presented for the aborted operation.
